// File: rtl/hdmi_text_render.sv
// hdmi_text_render: text-mode renderer with scroll, attribute blink, cursor and 16-colour palette, 5-clock latency
module hdmi_text_render #(
  parameter int COLS = 100,
  parameter int ROWS = 30,
  parameter int GLYPH_W = 10,
  parameter int GLYPH_H = 24,
  parameter int BLINK_FRAMES = 32,
  localparam int CW = $clog2(COLS),
  localparam int RW = $clog2(ROWS),
  localparam int HW = $clog2(GLYPH_H)
) (
  input  logic               clk,
  input  logic               reset_low,
  input  logic               in_active,
  input  logic               in_h_sync,
  input  logic               in_v_sync,
  input  logic               in_h_start,
  input  logic               in_v_start,
  input  logic [RW-1:0]      top_row,
  input  logic               cursor_enable,
  input  logic [RW-1:0]      cursor_row,
  input  logic [CW-1:0]      cursor_col,
  output logic               vram_valid,
  output logic [RW-1:0]      vram_row,
  output logic [CW-1:0]      vram_col,
  input  logic [7:0]         vram_char,
  input  logic [7:0]         vram_attr,
  output logic               glyph_ce,
  output logic [7:0]         glyph_char,
  output logic [HW-1:0]      glyph_row,
  input  logic [GLYPH_W-1:0] glyph_bits,
  output logic               out_active,
  output logic               out_h_sync,
  output logic               out_v_sync,
  output logic [23:0]        out_rgb
);
  localparam int PW = $clog2(GLYPH_W);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [PW-1:0] cp, cp_n;
  logic [CW:0] col, col_n;
  logic [HW-1:0] rp, rp_n, rp2;
  logic [RW:0] line, line_n, sum;
  logic [RW-1:0] top, top_n, vrow;
  logic synced, synced_n, text_n, fetch_n, match, cur1, cur_n;
  logic [FW-1:0] fcnt;
  logic phase;
  // pipeline control per pixel: {active, h_sync, v_sync, text, fetch, cursor}
  logic [5:0] d [4];
  logic [7:0] attr1, attr2, attr_c;
  logic [GLYPH_W-1:0] sh, bits;
  logic on, swap;
  logic [3:0] fg, bg, idx;
  logic [23:0] rgb_n;

  function automatic logic [7:0] lv(input logic b, input logic hi);
    return (b ? 8'hAA : 8'h00) + (hi ? 8'h55 : 8'h00);
  endfunction

  // next cell coordinates, scrolled VRAM row and cursor hit for the incoming pixel
  always_comb begin
    cp_n = in_h_start ? '0 : in_active ? (cp == PW'(GLYPH_W - 1) ? '0 : cp + 1'b1) : cp;
    col_n = in_h_start ? '0 : (in_active && cp == PW'(GLYPH_W - 1) && col != (CW+1)'(COLS)) ? col + 1'b1 : col;
    rp_n = !in_h_start ? rp : (in_v_start || rp == HW'(GLYPH_H - 1)) ? '0 : rp + 1'b1;
    line_n = !in_h_start ? line : in_v_start ? '0 :
             (rp == HW'(GLYPH_H - 1) && line != (RW+1)'(ROWS)) ? line + 1'b1 : line;
    top_n = in_v_start ? ({1'b0, top_row} >= (RW+1)'(ROWS) ? '0 : top_row) : top;
    synced_n = synced | in_v_start;
    sum = line_n + {1'b0, top_n};
    vrow = RW'(sum >= (RW+1)'(ROWS) ? sum - (RW+1)'(ROWS) : sum);
    text_n = synced_n && in_active && col_n < (CW+1)'(COLS) && line_n < (RW+1)'(ROWS);
    fetch_n = text_n && cp_n == '0;
    match = cursor_enable && vrow == cursor_row && col_n[CW-1:0] == cursor_col && rp_n >= HW'(GLYPH_H - 2);
    cur_n = fetch_n ? match : cur1;
  end

  // glyph pixel selection, blink and cursor colour choice, palette lookup
  always_comb begin
    bits = d[3][1] ? glyph_bits : sh;
    attr_c = d[3][1] ? attr1 : attr2;
    swap = d[3][0] && phase;
    on = bits[GLYPH_W-1] && !(attr_c[7] && !phase);
    fg = attr_c[3:0];
    bg = {1'b0, attr_c[6:4]};
    idx = (on ^ swap) ? fg : bg;
    rgb_n = (d[3][5] && d[3][2]) ? {lv(idx[2], idx[3]), lv(idx[1], idx[3]), lv(idx[0], idx[3])} : '0;
  end

  // cell counters, scroll latch, sync flag and blink phase
  always_ff @(posedge clk or negedge reset_low)
    if (!reset_low) begin
      cp <= '0;
      col <= '0;
      rp <= '0;
      line <= '0;
      top <= '0;
      synced <= 1'b0;
      fcnt <= '0;
      phase <= 1'b1;
    end else begin
      cp <= cp_n;
      col <= col_n;
      rp <= rp_n;
      line <= line_n;
      top <= top_n;
      synced <= synced_n;
      if (in_v_start && synced) begin
        fcnt <= (fcnt == FW'(BLINK_FRAMES - 1)) ? '0 : fcnt + 1'b1;
        phase <= (fcnt == FW'(BLINK_FRAMES - 1)) ? ~phase : phase;
      end
    end

  // VRAM request and per-pixel control pipeline
  always_ff @(posedge clk or negedge reset_low)
    if (!reset_low) begin
      vram_valid <= 1'b0;
      vram_row <= '0;
      vram_col <= '0;
      cur1 <= 1'b0;
      rp2 <= '0;
      d <= '{default: '0};
    end else begin
      vram_valid <= fetch_n;
      if (fetch_n) begin
        vram_row <= vrow;
        vram_col <= col_n[CW-1:0];
      end
      cur1 <= cur_n;
      rp2 <= rp;
      d[0] <= {in_active, in_h_sync, in_v_sync, text_n, fetch_n, cur_n};
      d[1] <= d[0];
      d[2] <= d[1];
      d[3] <= d[2];
    end

  // glyph ROM request and attribute capture as VRAM data returns
  always_ff @(posedge clk or negedge reset_low)
    if (!reset_low) begin
      glyph_ce <= 1'b0;
      glyph_char <= '0;
      glyph_row <= '0;
      attr1 <= '0;
    end else begin
      glyph_ce <= d[1][1];
      if (d[1][1]) begin
        glyph_char <= vram_char;
        glyph_row <= rp2;
        attr1 <= vram_attr;
      end
    end

  // pixel shifter, cell attribute hold and registered outputs
  always_ff @(posedge clk or negedge reset_low)
    if (!reset_low) begin
      sh <= '0;
      attr2 <= '0;
      out_active <= 1'b0;
      out_h_sync <= 1'b0;
      out_v_sync <= 1'b0;
      out_rgb <= '0;
    end else begin
      sh <= bits << 1;
      attr2 <= attr_c;
      out_active <= d[3][5];
      out_h_sync <= d[3][4];
      out_v_sync <= d[3][3];
      out_rgb <= rgb_n;
    end
endmodule

// File: tb/tb_hdmi_text_render.sv
// tb_hdmi_text_render: small-geometry bench with a pixel-level reference model and attribute table
module tb_hdmi_text_render;
  localparam int COLS = 6, ROWS = 5, GW = 4, GH = 4, BF = 2;
  localparam int HA = 28, HT = 34, VA = 24, VT = 27;

  logic clk = 0, reset_low = 1;
  logic in_active = 0, in_h_sync = 0, in_v_sync = 0, in_h_start = 0, in_v_start = 0;
  logic [2:0] top_row = 0, cursor_row = 0, cursor_col = 0;
  logic cursor_enable = 0;
  logic vram_valid, glyph_ce, out_active, out_h_sync, out_v_sync;
  logic [2:0] vram_row, vram_col;
  logic [7:0] vram_char = 0, vram_attr = 0, glyph_char;
  logic [1:0] glyph_row;
  logic [3:0] glyph_bits = 0;
  logic [23:0] out_rgb;

  hdmi_text_render #(.COLS(COLS), .ROWS(ROWS), .GLYPH_W(GW), .GLYPH_H(GH), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset_low(reset_low), .in_active(in_active), .in_h_sync(in_h_sync),
    .in_v_sync(in_v_sync), .in_h_start(in_h_start), .in_v_start(in_v_start), .top_row(top_row),
    .cursor_enable(cursor_enable), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .vram_valid(vram_valid), .vram_row(vram_row), .vram_col(vram_col), .vram_char(vram_char),
    .vram_attr(vram_attr), .glyph_ce(glyph_ce), .glyph_char(glyph_char), .glyph_row(glyph_row),
    .glyph_bits(glyph_bits), .out_active(out_active), .out_h_sync(out_h_sync),
    .out_v_sync(out_v_sync), .out_rgb(out_rgb));

  always #5 clk = ~clk;

  typedef struct {logic act, hs, vs; logic [23:0] rgb; int x, y, f;} exp_t;
  typedef struct {logic [7:0] attr; int frame; logic [23:0] fg, bg;} tv_t;

  logic [7:0] vchar [ROWS][COLS];
  logic [7:0] vattr [ROWS][COLS];
  logic [7:0] lvl [4] = '{8'h00, 8'h55, 8'hAA, 8'hFF};
  exp_t q[$];
  int nvec = 0, nerr = 0;
  bit glyph_fixed = 0, m_synced = 0, skip_line = 1, rnd = 0;
  int m_frame = -1, m_top = 0, cap_frame = -2;
  int fetch_cnt = 0, gce_cnt = 0, fetch_base = 0, gce_base = 0, lexp_n = 0, lexp_row = 0;
  int rst_f = -1, rst_y = 0, rst_x = 0;
  logic [2:0] last_row = 0;
  logic [23:0] cap_fg, cap_bg;

  function automatic logic [3:0] gfun(input logic [7:0] c, input int r);
    return glyph_fixed ? 4'b1000 : 4'((c * 13) + (r * 7) + (c >> 4));
  endfunction

  function automatic logic [23:0] pal(input logic [3:0] i);
    return {lvl[{i[2], i[3]}], lvl[{i[1], i[3]}], lvl[{i[0], i[3]}]};
  endfunction

  always @(posedge clk) begin
    if (vram_valid) begin
      vram_char <= vchar[vram_row][vram_col];
      vram_attr <= vattr[vram_row][vram_col];
      fetch_cnt <= fetch_cnt + 1;
      last_row <= vram_row;
    end
    if (glyph_ce) begin
      glyph_bits <= gfun(glyph_char, int'(glyph_row));
      gce_cnt <= gce_cnt + 1;
    end
  end

  task automatic fill_vram(input bit random, input logic [7:0] attr);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        vchar[r][c] = random ? 8'($urandom) : 8'((r * COLS + c) % 256);
        vattr[r][c] = random ? 8'($urandom) : attr;
      end
  endtask

  task automatic do_reset();
    exp_t z;
    z = '{act: 0, hs: 0, vs: 0, rgb: 0, x: -1, y: -1, f: -1};
    #2 reset_low = 0;
    #1 nvec++;
    if ({vram_valid, vram_row, vram_col, glyph_ce, glyph_char, glyph_row, out_active, out_h_sync,
         out_v_sync, out_rgb} !== '0) begin
      nerr++;
      $display("FAIL reset_state got vv=%b row=%0d col=%0d gce=%b gch=%h grow=%0d act=%b hs=%b vs=%b rgb=%h want all 0",
               vram_valid, vram_row, vram_col, glyph_ce, glyph_char, glyph_row, out_active,
               out_h_sync, out_v_sync, out_rgb);
    end
    @(posedge clk);
    @(negedge clk);
    reset_low = 1;
    q = {};
    repeat (4) q.push_back(z);
    m_synced = 0;
    m_frame = -1;
    skip_line = 1;
  endtask

  task automatic px(input int x, input int y);
    exp_t e;
    int c, l, vr, cx, ry;
    logic [7:0] ch, at;
    logic [3:0] bits;
    logic ph, on, cur;
    in_active = x < HA && y < VA;
    in_h_sync = x >= 30 && x < 32;
    in_v_sync = y == 25;
    in_h_start = in_active && x == 0;
    in_v_start = in_h_start && y == 0;
    if (in_v_start) begin
      if (m_synced) m_frame++;
      else begin
        m_synced = 1;
        m_frame = 0;
      end
      m_top = (top_row >= ROWS) ? 0 : int'(top_row);
    end
    e = '{act: in_active, hs: in_h_sync, vs: in_v_sync, rgb: 0, x: x, y: y, f: m_frame};
    c = x / GW; l = y / GH; cx = x % GW; ry = y % GH;
    if (in_active && m_synced && c < COLS && l < ROWS) begin
      vr = (l + m_top) % ROWS;
      ch = vchar[vr][c];
      at = vattr[vr][c];
      bits = gfun(ch, ry);
      ph = ((m_frame / BF) % 2) == 0;
      on = bits[GW-1-cx] && !(at[7] && !ph);
      cur = cursor_enable && ph && vr == int'(cursor_row) && c == int'(cursor_col) && ry >= GH - 2;
      e.rgb = pal((on ^ cur) ? at[3:0] : {1'b0, at[6:4]});
    end
    if (x == 0) begin
      if (!skip_line) begin
        nvec++;
        if (fetch_cnt - fetch_base != lexp_n || gce_cnt - gce_base != lexp_n ||
            (lexp_n > 0 && int'(last_row) != lexp_row)) begin
          nerr++;
          $display("FAIL line_fetch y=%0d got vram=%0d glyph=%0d row=%0d want %0d row %0d",
                   y, fetch_cnt - fetch_base, gce_cnt - gce_base, last_row, lexp_n, lexp_row);
        end
      end
      skip_line = 0;
      fetch_base = fetch_cnt;
      gce_base = gce_cnt;
      lexp_n = (in_active && m_synced && l < ROWS) ? COLS : 0;
      lexp_row = (l + m_top) % ROWS;
    end
    @(posedge clk);
    q.push_back(e);
    @(negedge clk);
    e = q.pop_front();
    nvec++;
    if ({out_active, out_h_sync, out_v_sync, out_rgb} !== {e.act, e.hs, e.vs, e.rgb}) begin
      nerr++;
      $display("FAIL pixel x=%0d y=%0d f=%0d got act=%b hs=%b vs=%b rgb=%h want act=%b hs=%b vs=%b rgb=%h",
               e.x, e.y, e.f, out_active, out_h_sync, out_v_sync, out_rgb, e.act, e.hs, e.vs, e.rgb);
    end
    if (e.f == cap_frame && e.y == 0 && e.x == 0) cap_fg = out_rgb;
    if (e.f == cap_frame && e.y == 0 && e.x == 1) cap_bg = out_rgb;
  endtask

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int y = 0; y < VT; y++)
        for (int x = 0; x < HT; x++) begin
          if (rnd && x == HA) begin
            cursor_enable = $urandom_range(0, 3) != 0;
            cursor_row = 3'($urandom_range(0, ROWS - 1));
            cursor_col = 3'($urandom_range(0, COLS - 1));
          end
          if (rnd && x == 3 && y % 5 == 0) top_row = 3'($urandom);
          if (rnd && x == 0 && y == VA) fill_vram(1, 8'h00);
          if (f == rst_f && y == rst_y && x == rst_x) do_reset();
          px(x, y);
        end
  endtask

  initial begin
    tv_t tv [8];
    tv[0] = '{attr: 8'h07, frame: 0, fg: 24'hAAAAAA, bg: 24'h000000};
    tv[1] = '{attr: 8'h9C, frame: 0, fg: 24'hFF5555, bg: 24'h0000AA};
    tv[2] = '{attr: 8'h9C, frame: 2, fg: 24'h0000AA, bg: 24'h0000AA};
    tv[3] = '{attr: 8'h9C, frame: 4, fg: 24'hFF5555, bg: 24'h0000AA};
    tv[4] = '{attr: 8'h1F, frame: 0, fg: 24'hFFFFFF, bg: 24'h0000AA};
    tv[5] = '{attr: 8'h7A, frame: 3, fg: 24'h55FF55, bg: 24'hAAAAAA};
    tv[6] = '{attr: 8'hE9, frame: 1, fg: 24'h5555FF, bg: 24'hAAAA00};
    tv[7] = '{attr: 8'hE9, frame: 3, fg: 24'hAAAA00, bg: 24'hAAAA00};
    fill_vram(0, 8'h07);
    do_reset();
    glyph_fixed = 1;
    for (int i = 0; i < 8; i++) begin
      do_reset();
      fill_vram(0, tv[i].attr);
      cap_frame = tv[i].frame;
      cap_fg = 'x;
      cap_bg = 'x;
      run_frames(tv[i].frame + 1);
      nvec += 2;
      if (cap_fg !== tv[i].fg) begin
        nerr++;
        $display("FAIL table%0d_fg attr=%h got %h want %h", i, tv[i].attr, cap_fg, tv[i].fg);
      end
      if (cap_bg !== tv[i].bg) begin
        nerr++;
        $display("FAIL table%0d_bg attr=%h got %h want %h", i, tv[i].attr, cap_bg, tv[i].bg);
      end
    end
    cap_frame = -2;
    glyph_fixed = 0;
    do_reset();
    fill_vram(1, 8'h00);
    top_row = 3'(ROWS - 1);
    run_frames(1);
    top_row = 3'd7;
    run_frames(1);
    cursor_enable = 1;
    cursor_row = 3'd2;
    cursor_col = 3'd3;
    top_row = 3'd1;
    run_frames(4);
    rnd = 1;
    rst_f = 2;
    rst_y = 9;
    rst_x = 13;
    run_frames(7);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/hdmi_text_render.md
# hdmi_text_render

Parametrised text-mode renderer between the display timing generator and the TMDS encoder. It is the successor of the fixed 100×30 monochrome text pipeline. It turns timing strobes into character-cell coordinates, with hardware scroll via `top_row`. It fetches a character and attribute byte per cell from VRAM and a glyph row from an external glyph ROM, then shifts out 24-bit RGB through a 16-colour palette, with attribute blink and a blinking underline cursor. Latency is fixed at 5 clocks, so syncs stay aligned with pixels.

## Interface
Parameters:
- `COLS`, 100, text columns per row
- `ROWS`, 30, text rows
- `GLYPH_W`, 10, glyph width in pixels (glyph ROM word width)
- `GLYPH_H`, 24, glyph height in pixel lines
- `BLINK_FRAMES`, 32, frames per blink half-period
- `CW`, `RW`, `HW` (derived, not overridable) = clog2(COLS), clog2(ROWS), clog2(GLYPH_H)

Ports:
- `clk`  in  1  pixel clock; the only clock
- `reset_low`  in  1  asynchronous, active-low reset
- `in_active`, `in_h_sync`, `in_v_sync`  in  1 each  timing generator outputs
- `in_h_start`  in  1  high on the first active pixel of each active line
- `in_v_start`  in  1  high together with `in_h_start` on the first active line of a frame
- `top_row`  in  RW  VRAM row shown at the top of the screen; sampled on `in_v_start`
- `cursor_enable`  in  1  enables the cursor
- `cursor_row`, `cursor_col`  in  RW, CW  cursor cell, in VRAM coordinates
- `vram_valid`  out  1  read strobe
- `vram_row`, `vram_col`  out  RW, CW  VRAM address
- `vram_char`, `vram_attr`  in  8 each  read data, valid 1 clock after `vram_valid`
- `glyph_ce`  out  1  glyph ROM read strobe
- `glyph_char`  out  8  character code sent to the glyph ROM
- `glyph_row`  out  HW  glyph pixel line sent to the glyph ROM
- `glyph_bits`  in  GLYPH_W  glyph row data, valid 1 clock after `glyph_ce`; MSB is the leftmost pixel
- `out_active`, `out_h_sync`, `out_v_sync`  out  1 each  delayed timing signals
- `out_rgb`  out  24  pixel colour as {R,G,B}, 8 bits each

## Operation
- **Cell counters.**
  - On `in_h_start`: `col`=0 and `col_pixel`=0. Otherwise, while `in_active`, `col_pixel` increments; when it reaches GLYPH_W−1 it wraps to 0 and `col` increments.
  - On `in_h_start` with `in_v_start`: `line`=0 and `row_pixel`=0.
  - On `in_h_start` without `in_v_start`: `row_pixel` increments; when it reaches GLYPH_H−1 it wraps to 0 and `line` increments.
- **Scroll.**
  - On `in_v_start`, `top_row` is latched. A latched value ≥ ROWS is replaced by 0.
  - VRAM row = `line` + latched top, minus ROWS if the sum is ≥ ROWS. The sum is computed in RW+1 bits.
- **Text area.** The text area is `line` < ROWS and `col` < COLS. Outside it, no VRAM or glyph access is made and the pixel is background index 0 (black).
- **VRAM fetch.** `vram_valid` pulses once per text cell, on the cycle the cell's `col_pixel`=0 is registered.
- **Glyph fetch.** The clock after the VRAM data returns, `glyph_ce` pulses with `glyph_char`=`vram_char` and `glyph_row`=`row_pixel`.
- **Shifter.** `glyph_bits` are loaded into a GLYPH_W shift register and shifted left one bit per clock.
- **Attributes.** `vram_attr` is latched together with the character:
  - [3:0] is the foreground index.
  - [6:4] is the background index.
  - [7] is blink.
- **Blink.**
  - A frame counter increments on each `in_v_start`. Every BLINK_FRAMES frames it clears and toggles `phase`.
  - After reset, `phase`=1 (visible) and the counter is 0.
  - If attr[7]=1 and `phase`=0, all glyph pixels show background.
- **Cursor.**
  - The cursor is shown when `cursor_enable`=1, `phase`=1, the cell's VRAM row/col equals `cursor_row`/`cursor_col`, and `row_pixel` ≥ GLYPH_H−2.
  - Where the cursor is shown, foreground and background are swapped for the whole cell width.
- **Palette.** For index i:
  - R uses bit 2, G uses bit 1, B uses bit 0.
  - Component = 0xAA if its bit is set, plus 0x55 if i[3] is set. This gives 0x00, 0x55, 0xAA or 0xFF.
- **Active gating.** `out_rgb` = 0 whenever the delayed active signal is 0.
- **Reset sync.** After reset, a `synced` flag is clear until the first `in_v_start`. While it is clear:
  - `vram_valid`=0 and `glyph_ce`=0.
  - `out_rgb`=0.
  - Syncs and active still propagate.

## Timing
- An input at cycle t appears on `out_active`/`out_h_sync`/`out_v_sync`/`out_rgb` at t+5, for every pixel.
- The `vram_valid` for a cell asserts at t+1, where t is the cell's first-pixel input cycle. `glyph_ce` asserts at t+3, the shift register loads at t+4, and the first pixel is at t+5.
- Address outputs are registered and held between strobes.
- Reset value of every output is 0: syncs, active, rgb, strobes and addresses.
- `reset_low` is asserted asynchronously and released synchronously by the upstream synchroniser. A reset mid-frame clears the counters and `synced`; rendering resumes at the next `in_v_start`.
- Input changes are handled as follows:
  - A `top_row` change mid-frame has no effect until the next `in_v_start`.
  - A `cursor_*` change takes effect at the next cell fetch.

## Test plan
- Default parameters, 1280×720 timing, VRAM char = (row·COLS+col) mod 256, attr 0x07 → cell (0,0) pixels at t+5 come from glyph 0 line 0. FG white 0xAAAAAA, BG 0x000000. Exactly 100 `vram_valid` pulses per active line, none for pixels 1000–1279.
- `top_row`=29 → screen line 0 reads VRAM row 29 and line 1 reads row 0. `top_row`=31 → treated as 0.
- attr 0x9C (blink, bg 1, fg 12) → FG 0xFF5555 while `phase`=1. BG 0x0000AA for all pixels in frames BLINK_FRAMES..2·BLINK_FRAMES−1.
- Cursor at (5,7), enabled → glyph lines 22–23 of that cell show inverted colours in visible phase only. No other cell changes.
- `reset_low` pulsed mid-line → all outputs 0 immediately. Zero VRAM/glyph strobes and black pixels until the next `in_v_start`. Output is then bit-exact with a clean run.
- `GLYPH_W`=8, `GLYPH_H`=16, `COLS`=80, `ROWS`=45 → 80 fetches per line, row wrap every 16 lines, latency still 5.
